// File: rtl/gemm_pkg.sv
// gemm_pkg: shared constants and FSM state type for the GEMM accelerator.
// Holds the tile geometry (4x4x4), operand/result widths and the sequencer states.
package gemm_pkg;

    localparam int unsigned TILE_M = 4;
    localparam int unsigned TILE_N = 4;
    localparam int unsigned TILE_K = 4;
    localparam int unsigned IN_W   = 8;
    localparam int unsigned OUT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/gemm_pe.sv
// gemm_pe: signed dot-product MAC, NumIp lanes per cycle, with accumulator clear.
// Ports: clk_i, rst_i (async high), en_i (accumulate), clr_i (load instead of add),
//        a_i/b_i packed operand lanes, acc_o accumulator (wraps mod 2^OutDataWidth).
module gemm_pe
    import gemm_pkg::*;
#(
    parameter int unsigned InDataWidth  = IN_W,
    parameter int unsigned OutDataWidth = OUT_W,
    parameter int unsigned NumIp        = TILE_K
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          clr_i,
    input  logic [NumIp*InDataWidth-1:0]  a_i,
    input  logic [NumIp*InDataWidth-1:0]  b_i,
    output logic [OutDataWidth-1:0]       acc_o
);

    logic signed [OutDataWidth-1:0]  acc_q;
    logic signed [OutDataWidth-1:0]  acc_d;
    logic signed [OutDataWidth-1:0]  dot;
    logic signed [InDataWidth-1:0]   av;
    logic signed [InDataWidth-1:0]   bv;
    logic signed [2*InDataWidth-1:0] prod;

    always_comb begin
        dot  = '0;
        av   = '0;
        bv   = '0;
        prod = '0;
        for (int k = 0; k < NumIp; k++) begin
            av   = a_i[k*InDataWidth +: InDataWidth];
            bv   = b_i[k*InDataWidth +: InDataWidth];
            prod = av * bv;
            // signed size cast sign-extends the full-precision product
            dot  = dot + OutDataWidth'(prod);
        end
        acc_d = acc_q;
        if (en_i) begin
            acc_d = clr_i ? dot : acc_q + dot;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/gemm_accelerator_top.sv
// gemm_accelerator_top: tiled C = A * B^T sequencer over single-port SRAMs, 4x4 PE array.
// Ports: clk_i, rst_i (async high), start_i, M/K/N_size_i, SRAM A/B addr+rdata,
//        SRAM C addr/wdata/we, done_o. Option: GEMM_SIZE_CHECK_EN rejects sizes not multiple of 4.
module gemm_accelerator_top
    import gemm_pkg::*;
#(
    parameter int unsigned InDataWidth   = IN_W,
    parameter int unsigned OutDataWidth  = OUT_W,
    parameter int unsigned InMemWidth    = 128,
    parameter int unsigned OutMemWidth   = 512,
    parameter int unsigned AddrWidth     = 12,
    parameter int unsigned SizeAddrWidth = 8,
    parameter int unsigned NumPE_M       = TILE_M,
    parameter int unsigned NumPE_N       = TILE_N,
    parameter int unsigned NumIp_K       = TILE_K,
    parameter int unsigned size_a_bus    = NumIp_K * InDataWidth,
    parameter int unsigned size_b_bus    = NumIp_K * InDataWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    input  logic [InMemWidth-1:0]    sram_a_rdata_i,
    input  logic [InMemWidth-1:0]    sram_b_rdata_i,
    output logic [OutMemWidth-1:0]   sram_c_wdata_o,
    output logic                     sram_c_we_o,
    output logic                     done_o
);

    localparam int unsigned TW = SizeAddrWidth - 2;

    state_e        state_q, state_d;
    logic [TW-1:0] mt_tot_q, mt_tot_d;
    logic [TW-1:0] kt_tot_q, kt_tot_d;
    logic [TW-1:0] nt_tot_q, nt_tot_d;
    logic [TW-1:0] mt_q, mt_d;
    logic [TW-1:0] kt_q, kt_d;
    logic [TW-1:0] nt_q, nt_d;
    logic          beat_q, beat_d;
    logic          first_q, first_d;

    logic [TW-1:0] m_tiles, k_tiles, n_tiles;
    logic          size_err;

    assign m_tiles = M_size_i[SizeAddrWidth-1:2];
    assign k_tiles = K_size_i[SizeAddrWidth-1:2];
    assign n_tiles = N_size_i[SizeAddrWidth-1:2];

`ifdef GEMM_SIZE_CHECK_EN
    assign size_err = |{M_size_i[1:0], K_size_i[1:0], N_size_i[1:0]};
`else
    logic unused_low_bits;
    assign unused_low_bits = ^{M_size_i[1:0], K_size_i[1:0], N_size_i[1:0]};
    assign size_err = 1'b0;
`endif

    // addresses: A/B use row stride K (= Kt*4), C uses row stride Nt
    logic [AddrWidth-1:0] k_full;
    logic [AddrWidth-1:0] a_addr, b_addr, c_addr;

    assign k_full = AddrWidth'({kt_tot_q, 2'b00});
    assign a_addr = AddrWidth'(mt_q) * k_full + AddrWidth'(kt_q);
    assign b_addr = AddrWidth'(nt_q) * k_full + AddrWidth'(kt_q);
    assign c_addr = AddrWidth'(mt_q) * AddrWidth'(nt_tot_q) + AddrWidth'(nt_q);

    logic [OutMemWidth-1:0] acc_flat;

    for (genvar m = 0; m < NumPE_M; m++) begin : g_m
        for (genvar n = 0; n < NumPE_N; n++) begin : g_n
            gemm_pe #(
                .InDataWidth (InDataWidth),
                .OutDataWidth(OutDataWidth),
                .NumIp       (NumIp_K)
            ) u_pe (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (beat_q),
                .clr_i (first_q),
                .a_i   (sram_a_rdata_i[m*size_a_bus +: size_a_bus]),
                .b_i   (sram_b_rdata_i[n*size_b_bus +: size_b_bus]),
                .acc_o (acc_flat[(m*NumPE_N+n)*OutDataWidth +: OutDataWidth])
            );
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mt_tot_q <= '0;
            kt_tot_q <= '0;
            nt_tot_q <= '0;
            mt_q     <= '0;
            kt_q     <= '0;
            nt_q     <= '0;
            beat_q   <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            mt_tot_q <= mt_tot_d;
            kt_tot_q <= kt_tot_d;
            nt_tot_q <= nt_tot_d;
            mt_q     <= mt_d;
            kt_q     <= kt_d;
            nt_q     <= nt_d;
            beat_q   <= beat_d;
            first_q  <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mt_tot_d = mt_tot_q;
        kt_tot_d = kt_tot_q;
        nt_tot_d = nt_tot_q;
        mt_d     = mt_q;
        kt_d     = kt_q;
        nt_d     = nt_q;
        // a read issued this cycle returns next cycle and is accumulated then
        beat_d   = 1'b0;
        first_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mt_tot_d = m_tiles;
                    kt_tot_d = k_tiles;
                    nt_tot_d = n_tiles;
                    mt_d     = '0;
                    kt_d     = '0;
                    nt_d     = '0;
                    if (size_err || m_tiles == '0 ||
                        k_tiles == '0 || n_tiles == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                beat_d  = 1'b1;
                first_d = (kt_q == '0);
                if (kt_q == kt_tot_q - TW'(1)) begin
                    kt_d    = '0;
                    state_d = ST_DRAIN;
                end else begin
                    kt_d = kt_q + TW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (nt_q == nt_tot_q - TW'(1)) begin
                    nt_d = '0;
                    if (mt_q == mt_tot_q - TW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        mt_d    = mt_q + TW'(1);
                        state_d = ST_LOAD;
                    end
                end else begin
                    nt_d    = nt_q + TW'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sram_a_addr_o  = '0;
        sram_b_addr_o  = '0;
        sram_c_addr_o  = '0;
        sram_c_wdata_o = '0;
        sram_c_we_o    = 1'b0;
        done_o         = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                sram_a_addr_o = a_addr;
                sram_b_addr_o = b_addr;
            end
            ST_WRITE: begin
                sram_c_addr_o  = c_addr;
                sram_c_wdata_o = acc_flat;
                sram_c_we_o    = 1'b1;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_gemm_accelerator_top.sv
// tb_gemm_accelerator_top: directed bench for gemm_accelerator_top.
// Models the A/B/C single-port SRAMs and compares against hand-computed results.
module tb_gemm_accelerator_top;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   m_sz, k_sz, n_sz;
    logic [11:0]  a_addr, b_addr, c_addr;
    logic [127:0] a_rd, b_rd;
    logic [511:0] c_wd;
    logic         c_we;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] mem_a [256];
    logic [127:0] mem_b [256];
    logic [511:0] mem_c [256];

    int wr_cnt, last_wr, done_at, done_cnt;
    int wr_addr_q[$];

    byte a_m [16][64];
    byte b_m [4][64];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        a_rd <= mem_a[a_addr[7:0]];
        b_rd <= mem_b[b_addr[7:0]];
    end

    gemm_accelerator_top dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .M_size_i       (m_sz),
        .K_size_i       (k_sz),
        .N_size_i       (n_sz),
        .sram_a_addr_o  (a_addr),
        .sram_b_addr_o  (b_addr),
        .sram_c_addr_o  (c_addr),
        .sram_a_rdata_i (a_rd),
        .sram_b_rdata_i (b_rd),
        .sram_c_wdata_o (c_wd),
        .sram_c_we_o    (c_we),
        .done_o         (done)
    );

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [127:0] wa, input logic [127:0] wb);
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = wa;
            mem_b[i] = wb;
        end
    endtask

    task automatic clear_c();
        for (int i = 0; i < 256; i++) mem_c[i] = '0;
        wr_addr_q.delete();
    endtask

    task automatic launch(input logic [7:0] m, input logic [7:0] k,
                          input logic [7:0] n);
        @(negedge clk);
        m_sz  = m;
        k_sz  = k;
        n_sz  = n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // i counts cycles after start acceptance; i=1 is the first cycle in LOAD
    task automatic run(input logic [7:0] m, input logic [7:0] k,
                       input logic [7:0] n, input int budget);
        clear_c();
        launch(m, k, n);
        wr_cnt   = 0;
        last_wr  = 0;
        done_at  = 0;
        done_cnt = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (c_we) begin
                mem_c[c_addr[7:0]] = c_wd;
                wr_addr_q.push_back(int'(c_addr));
                wr_cnt++;
                last_wr = i;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (done_at != 0 && i >= done_at + 2) break;
        end
        check("done_seen", done_at != 0, 1'b1);
    endtask

    task automatic check_run1(input string tag);
        check({tag, "_wr_cnt"}, wr_cnt, 4);
        check({tag, "_last_wr"}, last_wr, 72);
        check({tag, "_done_at"}, done_at, 73);
        check({tag, "_done_cnt"}, done_cnt, 1);
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            check({tag, "_addr"}, wr_addr_q[i], i);
            check({tag, "_data"}, mem_c[i], {16{32'd128}});
        end
    endtask

    initial begin
        logic [511:0] exp_w;
        int           acc;

        rst   = 1'b1;
        start = 1'b0;
        m_sz  = '0;
        k_sz  = '0;
        n_sz  = '0;
        fill('0, '0);
        clear_c();
        repeat (2) @(negedge clk);
        check("rst_we", c_we, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_a_addr", a_addr, 12'd0);
        check("rst_c_addr", c_addr, 12'd0);
        check("rst_wdata", c_wd, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A all 1, B all 2, K=64: every element 128
        fill({16{8'h01}}, {16{8'h02}});
        run(8'd4, 8'd64, 8'd16, 200);
        check_run1("t1");

        // random signed data, M=16 K=64 N=4
        fill('0, '0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 64; c++) a_m[r][c] = byte'($urandom);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 64; c++) b_m[r][c] = byte'($urandom);
        for (int mt = 0; mt < 4; mt++)
            for (int kt = 0; kt < 16; kt++)
                for (int mi = 0; mi < 4; mi++)
                    for (int ki = 0; ki < 4; ki++)
                        mem_a[mt*64+kt][(mi*4+ki)*8 +: 8] = a_m[mt*4+mi][kt*4+ki];
        for (int kt = 0; kt < 16; kt++)
            for (int ni = 0; ni < 4; ni++)
                for (int ki = 0; ki < 4; ki++)
                    mem_b[kt][(ni*4+ki)*8 +: 8] = b_m[ni][kt*4+ki];
        run(8'd16, 8'd64, 8'd4, 200);
        check("t2_wr_cnt", wr_cnt, 4);
        check("t2_last_wr", last_wr, 72);
        for (int mt = 0; mt < 4; mt++) begin
            exp_w = '0;
            for (int mi = 0; mi < 4; mi++)
                for (int ni = 0; ni < 4; ni++) begin
                    acc = 0;
                    for (int kk = 0; kk < 64; kk++)
                        acc += int'(a_m[mt*4+mi][kk]) * int'(b_m[ni][kk]);
                    exp_w[(mi*4+ni)*32 +: 32] = acc;
                end
            check("t2_data", mem_c[mt], exp_w);
        end

        // A all -1, B all 1, K=32: every element -32
        fill({16{8'hFF}}, {16{8'h01}});
        run(8'd32, 8'd32, 8'd32, 800);
        check("t3_wr_cnt", wr_cnt, 64);
        check("t3_last_wr", last_wr, 640);
        check("t3_done_at", done_at, 641);
        for (int i = 0; i < 64 && i < wr_addr_q.size(); i++) begin
            check("t3_addr", wr_addr_q[i], i);
            check("t3_data", mem_c[i], {16{32'hFFFFFFE0}});
        end

        // single tile of -128 operands: (-128)^2 * 4 = 65536
        fill({16{8'h80}}, {16{8'h80}});
        run(8'd4, 8'd4, 8'd4, 20);
        check("t4_wr_cnt", wr_cnt, 1);
        check("t4_last_wr", last_wr, 3);
        check("t4_done_at", done_at, 4);
        check("t4_data", mem_c[0], {16{32'd65536}});

        // reset in the middle of LOAD, then rerun
        fill({16{8'h01}}, {16{8'h02}});
        launch(8'd4, 8'd64, 8'd16);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_we", c_we, 1'b0);
        check("t5_rst_done", done, 1'b0);
        check("t5_rst_a_addr", a_addr, 12'd0);
        check("t5_rst_b_addr", b_addr, 12'd0);
        check("t5_rst_wdata", c_wd, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t5_idle_we", c_we, 1'b0);
            check("t5_idle_done", done, 1'b0);
            check("t5_idle_addr", a_addr, 12'd0);
        end
        run(8'd4, 8'd64, 8'd16, 200);
        check_run1("t5");

        // zero tile count: straight to DONE
        run(8'd0, 8'd4, 8'd4, 10);
        check("t6_wr_cnt", wr_cnt, 0);
        check("t6_done_at", done_at, 1);
        check("t6_done_cnt", done_cnt, 1);

        // M=6: rejected with size check, else treated as M=4
        run(8'd6, 8'd4, 8'd4, 20);
        check("t7_done_cnt", done_cnt, 1);
`ifdef GEMM_SIZE_CHECK_EN
        check("t7_wr_cnt", wr_cnt, 0);
        check("t7_done_at", done_at, 1);
`else
        check("t7_wr_cnt", wr_cnt, 1);
        check("t7_last_wr", last_wr, 3);
        check("t7_data", mem_c[0], {16{32'd8}});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gemm_accelerator_top.md
GEMM_ACCELERATOR_TOP -- requirements
Module: gemm_accelerator_top

Interface
REQ-001 SHALL have parameters (name, default, meaning): InDataWidth 8, operand width; OutDataWidth 32, result width; InMemWidth 128, A/B word; OutMemWidth 512, C word; AddrWidth 12, SRAM address; SizeAddrWidth 8, size ports; NumPE_M 4, NumPE_N 4, NumIp_K 4, tile dims; size_a_bus 32, size_b_bus 32, per-PE operand bus (NumIp_K*InDataWidth).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports (name, direction, width, meaning): clk_i in 1 clock; rst_i in 1 async active-high reset; start_i in 1 start request; M_size_i, K_size_i, N_size_i in SizeAddrWidth matrix dims; sram_a_addr_o, sram_b_addr_o, sram_c_addr_o out AddrWidth addresses; sram_a_rdata_i, sram_b_rdata_i in InMemWidth read data; sram_c_wdata_o out OutMemWidth; sram_c_we_o out 1; done_o out 1.
REQ-004 SHALL target single_port_memory instances: read data valid one cycle after address; write on clk edge when we=1.

Function
REQ-005 SHALL compute C[M][N] = A[M][K] * B^T, where B is stored as N rows of K; operands signed 8-bit, products and accumulation signed 32-bit, wrapping mod 2^32.
REQ-006 SHALL use tile counts Mt=M>>2, Kt=K>>2, Nt=N>>2, with all three latched on start acceptance.
REQ-007 SHALL read A tile (mt,kt) at address mt*K+kt; element (m_in,k_in) at bits [(m_in*4+k_in)*8 +: 8].
REQ-008 SHALL read B tile (nt,kt) at address nt*K+kt; element (n_in,k_in) at bits [(n_in*4+k_in)*8 +: 8].
REQ-009 SHALL write C tile (mt,nt) at address mt*Nt+nt; element (m_in,n_in) at bits [(m_in*4+n_in)*32 +: 32].
REQ-010 SHALL use a 4x4 PE array, each PE adding a 4-term dot product per cycle.
REQ-011 SHALL use FSM states IDLE, LOAD, DRAIN, WRITE, DONE; tile loop mt outer, nt inner.
REQ-012 IDLE: SHALL accept start_i=1 and go to LOAD; start_i is ignored in every other state.
REQ-013 LOAD: SHALL issue one A/B read pair per cycle for kt=0..Kt-1; accumulators are cleared on the first beat; each returned beat accumulates one cycle later.
REQ-014 DRAIN: SHALL last one cycle, accumulating the final beat.
REQ-015 WRITE: SHALL assert sram_c_we_o for exactly one cycle with full tile data, then go to the next tile's LOAD, or to DONE after the last tile.
REQ-016 DONE: SHALL assert done_o high for exactly one cycle, then return to IDLE.
REQ-017 Latency: SHALL be Mt*Nt*(Kt+2) cycles from start acceptance to the last write, with done the following cycle.
REQ-018 If Mt, Kt or Nt is 0, SHALL go directly to DONE with no reads or writes.
REQ-019 Caller guarantees all addresses fit AddrWidth; SHALL otherwise truncate them (wrap).
REQ-020 SHALL hold sram_c_we_o at 0 outside WRITE; addresses are don't-care when unused.

Reset
REQ-021 rst_i SHALL force IDLE immediately, including mid-operation; all addresses, sram_c_wdata_o, sram_c_we_o, done_o and accumulators SHALL be 0.
REQ-022 After reset release, SHALL accept a new start normally.

Configuration
REQ-023 With GEMM_SIZE_CHECK_EN defined, any latched size with bits[1:0]!=0 SHALL go to DONE with no reads or writes; without it, low bits SHALL be silently truncated.

Structure
REQ-024 Package gemm_pkg SHALL hold tile constants (4,4,4), operand/result widths and the FSM state enum.
REQ-025 Sub-module gemm_pe (one 4-input signed dot-product MAC with clear) SHALL be instantiated 16 times.

Verification
REQ-026 M=4,K=64,N=16, A all 1, B all 2 -> 4 writes at C addr 0..3, every element 128, done one pulse.
REQ-027 M=16,K=64,N=4, random signed data -> C addr 0..3 match software golden model bit-exactly.
REQ-028 M=32,K=32,N=32, A all 0xFF, B all 1 -> 64 writes, every element 0xFFFFFFE0.
REQ-029 M=4,K=4,N=4, all operands 0x80 -> one write, every element 65536, 3 cycles start-to-write.
REQ-030 Assert rst_i during LOAD of run 1 -> we/done stay 0, FSM IDLE; rerun the same sizes -> correct results.
REQ-031 M=6 with GEMM_SIZE_CHECK_EN -> no writes, done one cycle after DONE entry; without the macro, treated as M=4.
